// File: rtl/can_bit_sampler_if.sv
// can_bit_sampler_if: receive-side link between the CAN bit sampler and the frame decoder.
// Signals:
//   can_rx         raw asynchronous bus line, 1 = recessive
//   destuff_en     decoder asks for destuffing (SOF .. end of CRC)
//   sample         one-clock strobe, destuffed bit valid on can_data
//   can_data       last sampled bit, held between strobes
//   stuff_bit      one-clock pulse when a stuff bit is dropped
//   stuffing_error one-clock pulse on a sixth equal bit
//   bus_idle       11 recessive bits seen since the last dominant bit
// Modports: slave = sampler side, master = decoder/line side.
interface can_bit_sampler_if;
    logic can_rx;
    logic destuff_en;
    logic sample;
    logic can_data;
    logic stuff_bit;
    logic stuffing_error;
    logic bus_idle;
    modport master (output can_rx, destuff_en,
                    input  sample, can_data, stuff_bit, stuffing_error, bus_idle);
    modport slave  (input  can_rx, destuff_en,
                    output sample, can_data, stuff_bit, stuffing_error, bus_idle);
endinterface

// File: rtl/can_bit_sampler.sv
// can_bit_sampler: CAN bit timing recovery (hard sync + SJW-limited resync) and destuffer.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  can_bit_sampler_if.slave (can_rx, destuff_en in; sample, can_data,
//        stuff_bit, stuffing_error, bus_idle out)
// Optional feature: define CAN_TRIPLE_SAMPLE_EN to take the raw bit as the majority of
// three tq-spaced captures ending at the sample point (needs TSEG1 >= 3).
module can_bit_sampler #(
    parameter int BRP   = 4,
    parameter int TSEG1 = 13,
    parameter int TSEG2 = 2,
    parameter int SJW   = 1
) (
    input logic clk,
    input logic rst,
    can_bit_sampler_if.slave bus
);
    typedef enum logic [1:0] {SYNC, SEG1, SEG2} seg_t;
    localparam logic [7:0] T1 = 8'(TSEG1);
    localparam logic [7:0] T2 = 8'(TSEG2);
    localparam logic [7:0] SJ = 8'(SJW);
    localparam logic [7:0] BP = 8'(BRP - 1);

    seg_t       state_q, state_d;
    logic [7:0] psc_q, psc_d, tq_q, tq_d, ext_q, ext_d, short_q, short_d;
    logic [7:0] e_elapsed, r_left, ext_new, short_new, short_eff;
    logic [2:0] run_q, run_d;
    logic [3:0] idle_q, idle_d;
    logic       sync1_q, rx_s_q, rx_prev_q;
    logic       run_val_q, run_val_d, last_q, last_d, done_q, done_d;
    logic       sample_q, sample_d, data_q, data_d, stuff_q, stuff_d, err_q, err_d;
    logic       tick, fall, idle, hard, resync, seg1_end, seg2_end, in_seg2, sp, raw;

`ifdef CAN_TRIPLE_SAMPLE_EN
    logic [1:0] cap_q, cap_d;
    // The two early captures sit at fixed tq positions so a SEG1 extension does not move them.
    always_comb begin
        cap_d = cap_q;
        if (state_q == SEG1 && tick && tq_q == T1 - 8'd3) cap_d[0] = rx_s_q;
        if (state_q == SEG1 && tick && tq_q == T1 - 8'd2) cap_d[1] = rx_s_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cap_q <= 2'b11;
        else     cap_q <= cap_d;
    end
    assign raw = (cap_q[0] & cap_q[1]) | (cap_q[0] & rx_s_q) | (cap_q[1] & rx_s_q);
`else
    assign raw = rx_s_q;
`endif

    assign idle     = idle_q == 4'd11;
    assign fall     = rx_prev_q & ~rx_s_q;
    assign tick     = psc_q == BP;
    assign hard     = fall & idle;
    assign seg1_end = state_q == SEG1 && tick && tq_q + 8'd1 >= T1 + ext_q;
    // An edge on the sample-point clock is treated as SEG2 tq 0.
    assign in_seg2  = state_q == SEG2 || seg1_end;
    assign resync   = fall & ~idle & last_q & ~done_q & (state_q != SYNC);
    assign e_elapsed = tq_q + 8'd1;
    assign ext_new   = e_elapsed < SJ ? e_elapsed : SJ;
    assign r_left    = T2 - (state_q == SEG2 ? tq_q : 8'd0);
    assign short_new = r_left < SJ ? r_left : SJ;
    assign short_eff = resync && in_seg2 ? short_new : short_q;
    // ">=" lets a shortening equal to the remaining tq end SEG2 on the current tick.
    assign seg2_end = state_q == SEG2 && tick && tq_q + 8'd1 >= T2 - short_eff;
    assign sp       = seg1_end & ~hard;

    always_comb begin
        psc_d   = tick ? 8'd0 : psc_q + 8'd1;
        state_d = state_q;
        tq_d    = tq_q;
        ext_d   = ext_q;
        short_d = short_q;
        done_d  = done_q;
        if (resync) begin
            done_d  = 1'b1;
            ext_d   = in_seg2 ? ext_q : ext_new;
            short_d = in_seg2 ? short_new : short_q;
        end
        if (tick) begin
            tq_d = tq_q + 8'd1;
            if (state_q == SYNC || seg1_end) begin
                state_d = state_q == SYNC ? SEG1 : SEG2;
                tq_d    = 8'd0;
            end else if (seg2_end) begin
                state_d = SYNC;
                tq_d    = 8'd0;
                ext_d   = 8'd0;
                short_d = 8'd0;
                done_d  = 1'b0;
            end
        end
        if (hard) begin
            psc_d   = 8'd0;
            state_d = SYNC;
            tq_d    = 8'd0;
            ext_d   = 8'd0;
            short_d = 8'd0;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        sample_d  = 1'b0;
        stuff_d   = 1'b0;
        err_d     = 1'b0;
        data_d    = data_q;
        run_d     = run_q;
        run_val_d = run_val_q;
        last_d    = last_q;
        idle_d    = hard ? 4'd0 : idle_q;
        if (sp) begin
            last_d    = raw;
            run_val_d = raw;
            if (bus.destuff_en && run_q == 3'd5) begin
                stuff_d = raw != run_val_q;
                err_d   = raw == run_val_q;
                run_d   = 3'd1;
            end else begin
                sample_d = 1'b1;
                data_d   = raw;
                run_d    = bus.destuff_en && raw == run_val_q ? run_q + 3'd1 : 3'd1;
            end
            idle_d = err_d || !raw ? 4'd0 : (idle ? idle_q : idle_q + 4'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= SYNC;
            psc_q     <= 8'd0;
            tq_q      <= 8'd0;
            ext_q     <= 8'd0;
            short_q   <= 8'd0;
            done_q    <= 1'b0;
            run_q     <= 3'd0;
            run_val_q <= 1'b1;
            last_q    <= 1'b1;
            idle_q    <= 4'd0;
            sample_q  <= 1'b0;
            data_q    <= 1'b1;
            stuff_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync1_q   <= bus.can_rx;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            psc_q     <= psc_d;
            tq_q      <= tq_d;
            ext_q     <= ext_d;
            short_q   <= short_d;
            done_q    <= done_d;
            run_q     <= run_d;
            run_val_q <= run_val_d;
            last_q    <= last_d;
            idle_q    <= idle_d;
            sample_q  <= sample_d;
            data_q    <= data_d;
            stuff_q   <= stuff_d;
            err_q     <= err_d;
        end
    end

    assign bus.sample         = sample_q;
    assign bus.can_data       = data_q;
    assign bus.stuff_bit      = stuff_q;
    assign bus.stuffing_error = err_q;
    assign bus.bus_idle       = idle;
endmodule
